// File: rtl/rx_frame_buffer_pkg.sv
// Shared types and size helpers for the serial frame receiver.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package rx_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Word-index width; never below 1 so address ports stay legal.
    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Serial bits per word: one trailing even-parity bit when parity is built in.
    function automatic int word_bits(input int data_w);
`ifdef RX_FRAME_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

endpackage

// File: rtl/rx_frame_buffer_if.sv
// Serial-in / frame-read bundle between link source, consumer and receiver.
// Latency: n/a (wires only).
// Backpressure: rx_ready low means bits offered now are dropped and flagged.
interface rx_frame_buffer_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int AW = rx_frame_pkg::calc_aw(DEPTH);

    logic              tx_vld;
    logic              tx_data;
    logic              rx_ready;
    logic              rx_finish;
    logic              frame_ack;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_vld;
    logic              overrun;
    logic              par_err;

    modport master (
        output tx_vld, tx_data, frame_ack, rd_en, rd_addr,
        input  rx_ready, rx_finish, rd_data, rd_vld, overrun, par_err
    );

    modport slave (
        input  tx_vld, tx_data, frame_ack, rd_en, rd_addr,
        output rx_ready, rx_finish, rd_data, rd_vld, overrun, par_err
    );
endinterface

// File: rtl/rx_frame_buffer_word_ram.sv
// Frame word store: DATA_W x DEPTH, synchronous write, registered read.
// Latency: rd_en at edge N -> rd_data/rd_vld at N+1; same-address write returns old data.
// Backpressure: none; accepts a read and a write every cycle.
module rx_word_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_vld
);
    localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              in_range;

    // Addresses past the last word exist only for non-power-of-two depths; they read as zero.
    assign in_range = ({1'b0, rd_addr} < DEPTH_V);

    // Array write; the storage itself is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read; data holds between reads, so a same-edge write is seen only next read.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                rd_data <= in_range ? mem_q[rd_addr] : '0;
            end
        end
    end
endmodule

// File: rtl/rx_frame_buffer.sv
// Serial MSB-first receiver packing bits into DATA_W words, DEPTH words per frame (parity: RX_FRAME_PARITY_EN).
// Latency: last serial bit -> rx_finish after 1 cycle; read port 1 cycle.
// Backpressure: rx_ready drops while a frame is held; bits then are dropped and set overrun until frame_ack.
module rx_frame_buffer
    import rx_frame_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              clr,
    rx_frame_buffer_if.slave  bus
);
    localparam int AW = calc_aw(DEPTH);
    localparam int WB = word_bits(DATA_W);
    localparam int CW = $clog2(WB);
    localparam logic [CW-1:0] LAST_BIT  = CW'(WB - 1);
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

    state_t            state_q;
    logic [CW-1:0]     bit_cnt_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [DATA_W-1:0] shr_q;
    logic [DATA_W-1:0] shr_d;
    logic [DATA_W-1:0] word_d;
    logic              rx_ready_q;
    logic              rx_finish_q;
    logic              overrun_q;
    logic              par_err_q;
    logic              last_bit;
    logic              par_bad;
    logic              wr_en;

    // The final serial bit of a word is being offered this cycle.
    assign last_bit = (state_q == RECV) && (bit_cnt_q == LAST_BIT);
    assign wr_en    = last_bit && bus.tx_vld;

`ifdef RX_FRAME_PARITY_EN
    // The trailing parity bit is checked but never shifted in, so shr already holds the word.
    assign word_d  = shr_q;
    assign shr_d   = last_bit ? shr_q : {shr_q[DATA_W-2:0], bus.tx_data};
    assign par_bad = (^shr_q) ^ bus.tx_data;
`else
    assign word_d  = {shr_q[DATA_W-2:0], bus.tx_data};
    assign shr_d   = word_d;
    assign par_bad = 1'b0;
`endif

    // Frame FSM with counters, shift register and registered status outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            shr_q       <= '0;
            rx_ready_q  <= 1'b1;
            rx_finish_q <= 1'b0;
            overrun_q   <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.tx_vld) begin
                        shr_q     <= shr_d;
                        bit_cnt_q <= CW'(1);
                        state_q   <= RECV;
                    end
                end
                RECV: begin
                    if (bus.tx_vld) begin
                        shr_q <= shr_d;
                        if (last_bit) begin
                            bit_cnt_q <= '0;
                            if (par_bad) begin
                                par_err_q <= 1'b1;
                            end
                            if (wr_ptr_q == LAST_WORD) begin
                                wr_ptr_q    <= '0;
                                state_q     <= DONE;
                                rx_ready_q  <= 1'b0;
                                rx_finish_q <= 1'b1;
                            end else begin
                                wr_ptr_q <= wr_ptr_q + 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.tx_vld) begin
                        overrun_q <= 1'b1;
                    end
                    // Ack is assigned last so it wins over a same-cycle overrun.
                    if (bus.frame_ack) begin
                        state_q     <= IDLE;
                        rx_ready_q  <= 1'b1;
                        rx_finish_q <= 1'b0;
                        overrun_q   <= 1'b0;
                        par_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.rx_finish = rx_finish_q;
    assign bus.overrun   = overrun_q;
    assign bus.par_err   = par_err_q;

    rx_word_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .clr     (clr),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (word_d),
        .rd_en   (bus.rd_en),
        .rd_addr (bus.rd_addr),
        .rd_data (bus.rd_data),
        .rd_vld  (bus.rd_vld)
    );
endmodule

// File: tb/tb_rx_frame_buffer.sv
// Directed bench for rx_frame_buffer: frames, gaps, overrun, mid-frame reset, collision, parity.
// Latency: n/a.
// Backpressure: n/a.
module tb_rx_frame_buffer;
    typedef logic [7:0] frame_t [4];

`ifdef RX_FRAME_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;

    rx_frame_buffer_if #(.DATA_W(8), .DEPTH(4)) bus ();

    rx_frame_buffer #(.DATA_W(8), .DEPTH(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Read-port monitor: every rd_vld must match the oldest queued expectation.
    always @(negedge clk) begin
        if (clr && bus.rd_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got rd_vld=1 data %0h, expected no read", bus.rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.rd_data !== mon_exp) begin
                    errors++;
                    $display("FAIL rd_data: got %0h, expected %0h", bus.rd_data, mon_exp);
                end
            end
        end
    end

    task automatic rd(input logic [1:0] addr, input logic [7:0] exp);
        exp_q.push_back(exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        step();
        bus.rd_en = 1'b0;
        chk("rd_vld_latency", {31'd0, bus.rd_vld}, 32'd1);
    endtask

    task automatic read_frame(input frame_t w);
        for (int a = 0; a < 4; a++) rd(a[1:0], w[a]);
    endtask

    task automatic ack();
        bus.frame_ack = 1'b1;
        step();
        bus.frame_ack = 1'b0;
        chk("ack_ready", {31'd0, bus.rx_ready}, 32'd1);
        chk("ack_finish", {31'd0, bus.rx_finish}, 32'd0);
        chk("ack_par_err", {31'd0, bus.par_err}, 32'd0);
    endtask

    // Sends a frame MSB-first with optional random gaps; coll_word >= 0 reads that
    // word's address on its final bit (expect old) and again on the next bit (expect new).
    task automatic send_frame(input frame_t w, input logic [3:0] bad, input int gap,
                              input int coll_word, input logic [7:0] coll_old);
        logic bits [$];
        int   wb;
        int   n;
        int   g;
        logic sticky;
        wb = PAR_EN ? 9 : 8;
        for (int k = 0; k < 4; k++) begin
            for (int i = 7; i >= 0; i--) bits.push_back(w[k][i]);
            if (PAR_EN) bits.push_back(bad[k] ? ~(^w[k]) : (^w[k]));
        end
        n = bits.size();
        sticky = 1'b0;
        for (int b = 0; b < n; b++) begin
            g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
            repeat (g) step();
            if (b == n - 1) begin
                chk("no_early_finish", {31'd0, bus.rx_finish}, 32'd0);
                chk("ready_in_recv", {31'd0, bus.rx_ready}, 32'd1);
            end
            bus.tx_vld  = 1'b1;
            bus.tx_data = bits[b];
            if (coll_word >= 0 && b == (coll_word + 1) * wb - 1) begin
                exp_q.push_back(coll_old);
                bus.rd_en = 1'b1;
                bus.rd_addr = coll_word[1:0];
            end
            if (coll_word >= 0 && b == (coll_word + 1) * wb) begin
                exp_q.push_back(w[coll_word]);
                bus.rd_en = 1'b1;
                bus.rd_addr = coll_word[1:0];
            end
            step();
            bus.tx_vld = 1'b0;
            bus.rd_en  = 1'b0;
            if ((b + 1) % wb == 0) begin
                sticky = sticky | bad[(b + 1) / wb - 1];
                chk("par_err_word", {31'd0, bus.par_err}, {31'd0, sticky & PAR_EN});
            end
        end
        chk("finish_after_last", {31'd0, bus.rx_finish}, 32'd1);
        chk("ready_low_done", {31'd0, bus.rx_ready}, 32'd0);
    endtask

    initial begin
        frame_t f1;
        frame_t f3;
        frame_t f4;
        frame_t f5;
        f1 = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
        f3 = '{8'h11, 8'h22, 8'h33, 8'h44};
        f4 = '{8'h55, 8'h66, 8'h77, 8'h88};
        f5 = '{8'h0F, 8'h07, 8'h5A, 8'hC3};

        clr           = 1'b0;
        bus.tx_vld    = 1'b0;
        bus.tx_data   = 1'b0;
        bus.frame_ack = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        repeat (3) step();
        chk("rst_ready", {31'd0, bus.rx_ready}, 32'd1);
        chk("rst_finish", {31'd0, bus.rx_finish}, 32'd0);
        chk("rst_rd_vld", {31'd0, bus.rd_vld}, 32'd0);
        chk("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
        chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
        chk("rst_par_err", {31'd0, bus.par_err}, 32'd0);
        clr = 1'b1;
        step();

        // Back-to-back frame and readback.
        send_frame(f1, 4'b0000, 0, -1, 8'h00);
        read_frame(f1);

        // Bits offered while a frame is held are dropped and flagged.
        bus.tx_vld  = 1'b1;
        bus.tx_data = 1'b1;
        repeat (3) step();
        bus.tx_vld = 1'b0;
        chk("overrun_set", {31'd0, bus.overrun}, 32'd1);
        chk("overrun_finish_held", {31'd0, bus.rx_finish}, 32'd1);
        read_frame(f1);
        // Ack together with a stray bit: ack wins.
        bus.tx_vld = 1'b1;
        ack();
        bus.tx_vld = 1'b0;
        chk("overrun_cleared", {31'd0, bus.overrun}, 32'd0);

        // Same frame with random gaps.
        send_frame(f1, 4'b0000, 5, -1, 8'h00);
        read_frame(f1);
        ack();

        // Reset after 13 bits discards the partial word.
        for (int i = 0; i < 13; i++) begin
            bus.tx_vld  = 1'b1;
            bus.tx_data = i[0];
            step();
        end
        bus.tx_vld = 1'b0;
        clr = 1'b0;
        step();
        chk("midrst_ready", {31'd0, bus.rx_ready}, 32'd1);
        clr = 1'b1;
        step();
        send_frame(f3, 4'b0000, 0, -1, 8'h00);
        read_frame(f3);
        ack();

        // Read of word 1 on the edge it is written returns old data, then new.
        send_frame(f4, 4'b0000, 0, 1, 8'h22);
        read_frame(f4);
        ack();

        if (PAR_EN) begin
            send_frame(f5, 4'b0010, 0, -1, 8'h00);
            chk("par_err_frame", {31'd0, bus.par_err}, 32'd1);
            rd(2'd0, 8'h0F);
            rd(2'd1, 8'h07);
            ack();
        end

        // Drain outstanding reads with a bounded wait.
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) step();
        chk("reads_drained", exp_q.size(), 32'd0);
        step();
        chk("rd_vld_idle", {31'd0, bus.rd_vld}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rx_frame_buffer.md
Name: rx_frame_buffer

Overview:
- Parametrised serial receiver: shifts `tx_data` bits qualified by `tx_vld` into `DATA_W`-bit words and stores `DEPTH` words per frame in an internal RAM.
- Signals frame completion, holds the frame for a consumer read port, and re-arms on an explicit acknowledge.
- Sits at the RX end of the TX/RX link. Successor to the fixed 8-bit, 4-word receiver: adds width/depth parameters, a read port, a frame handshake and overrun detection.

Parameters:
- DATA_W, 8, bits per word (>=2).
- DEPTH, 4, words per frame (>=2). AW = $clog2(DEPTH).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- clr  in  1  asynchronous active-low reset.
- tx_vld  in  1  qualifies `tx_data` as one serial bit this cycle.
- tx_data  in  1  serial bit, MSB-first.
- rx_ready  out  1  receiver accepting bits.
- rx_finish  out  1  level: complete frame held in RAM.
- frame_ack  in  1  consumer releases frame; 1-cycle pulse.
- rd_en  in  1  read request.
- rd_addr  in  AW  read word index.
- rd_data  out  DATA_W  read result.
- rd_vld  out  1  `rd_data` valid.
- overrun  out  1  sticky: a bit arrived while `rx_ready`=0.
- par_err  out  1  sticky parity error (see Optional Feature).

Behaviour:
- Reset (`clr`=0, async):
  - state=IDLE; bit_cnt=0; wr_ptr=0; shift reg=0.
  - Outputs: `rx_ready`=1, `rx_finish`=0, `rd_vld`=0, `rd_data`=0, `overrun`=0, `par_err`=0.
  - RAM contents are not reset.
- States: IDLE, RECV, DONE.
- IDLE:
  - `rx_ready`=1.
  - `tx_vld`=1 -> shift bit in, bit_cnt=1, go RECV.
- RECV:
  - `rx_ready`=1.
  - Each `tx_vld` shifts: shr <= {shr[DATA_W-2:0], tx_data}; bit_cnt++.
  - On the cycle the last bit of a word arrives (bit_cnt==WORD_BITS-1 and `tx_vld`), the RAM write fires that same edge with the combined next shift value at address wr_ptr. Then bit_cnt=0 and wr_ptr++.
  - Cycles without `tx_vld` hold all state; gaps of any length are legal.
- Word-to-frame completion:
  - Last bit of word DEPTH-1 -> next cycle state=DONE, `rx_finish`=1, `rx_ready`=0, wr_ptr wraps to 0.
- DONE:
  - `rx_finish` and `rx_ready`=0 hold until `frame_ack`.
  - `tx_vld`=1 here: bit dropped, `overrun`<=1.
  - `frame_ack`=1 -> next cycle IDLE, `rx_finish`=0, `rx_ready`=1, sticky flags cleared.
  - `frame_ack` and `tx_vld` in the same DONE cycle: bit dropped and `overrun` set, then the ack clears it. Net result: `overrun`=0 after the ack (ack wins).
  - `frame_ack` outside DONE is ignored.
- Read port:
  - Synchronous; `rd_en` at edge N -> `rd_data`=RAM[rd_addr], `rd_vld`=1 at N+1.
  - `rd_vld`=0 otherwise; `rd_data` holds its last value.
  - Reads are legal in any state.
  - Read and write to the same address in the same cycle returns old data.
  - `rd_addr` >= DEPTH (non-power-of-2 DEPTH) returns 0.
- Reset mid-frame: partial word discarded; wr_ptr=0; RAM not cleared.
- Latency: last serial bit to `rx_finish` = 1 cycle.

Optional Feature:
- Macro: RX_FRAME_PARITY_EN.
- Defined:
  - WORD_BITS = DATA_W+1. Each word is followed by an even-parity bit, which is not stored.
  - If XOR(word bits, parity bit)=1, set `par_err` (sticky until `frame_ack`/reset).
  - The word is still written.
- Undefined:
  - WORD_BITS = DATA_W.
  - `par_err` tied 0; port kept for a stable interface.

Decomposition:
- Package `rx_frame_pkg`: state typedef enum {IDLE, RECV, DONE}; localparam function for AW; WORD_BITS derivation.
- One sub-module `rx_word_ram`: DATA_W x DEPTH, synchronous write, registered read, no reset on the array.
- FSM, counters and shift register stay in the top.

Test Plan:
- Reset then frame: DATA_W=8, DEPTH=4; send bytes 0xA5,0x3C,0xFF,0x01 MSB-first, `tx_vld` every cycle.
  - `rx_finish`=1 exactly 1 cycle after bit 32; `rx_ready`=0.
  - Reads of addr 0..3 return A5,3C,FF,01 with `rd_vld` 1 cycle after `rd_en`.
- Gapped input: the same frame with random `tx_vld` gaps of 0-5 cycles -> identical RAM contents; no early `rx_finish`.
- Overrun: in DONE drive `tx_vld`=1 for 3 cycles.
  - `overrun`=1; RAM unchanged.
  - `frame_ack` -> `overrun`=0, `rx_ready`=1 next cycle.
- Reset mid-frame: assert `clr`=0 after 13 bits, release, send full frame 0x11,0x22,0x33,0x44 -> stored words exactly 11,22,33,44 at addr 0..3.
- Parity (RX_FRAME_PARITY_EN): send 0x0F+parity 0 (good), then 0x07+parity 0 (bad) -> `par_err`=1 after the second word; both words stored; cleared by `frame_ack`.
- Read/write collision: `rd_en` on addr 1 during the cycle word 1 is written -> old data returned; a re-read the next cycle returns the new word.
